// File: rtl/round_ctrl.sv
// -----------------------------------------------------------------------------
// round_ctrl -- game-round sequencer and bell arbiter for the two-player card game.
//
// Takes the decoded flip and bell key pulses and produces a one-cycle deal strobe
// for the random/card path. After each deal it opens a bell window. It arbitrates
// bell presses, including presses that arrive in the same cycle. It runs a
// req/ack handshake with the score logic and flags end-of-game when the deck
// is exhausted.
//
// Optional feature (compile-time macro PENALTY_LOCK_EN):
//   When defined, a wrong bell locks that player's bell for LOCK_DEALS deals.
//   When undefined, no lock counters exist and every bell press is eligible.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset (0 = reset)
//   start        in   one-cycle pulse, begins a game from IDLE or OVER
//   flip1/flip2  in   flip-key pulses, player 1 / player 2
//   bell1/bell2  in   bell-key pulses, player 1 / player 2
//   right        in   card-match verdict, sampled in JUDGE
//   score_ack    in   score logic accepted the pending update
//   deal_en      out  one-cycle deal strobe
//   whose        out  current turn (0 = P1, 1 = P2)
//   cards_dealt  out  cards dealt in this game
//   score_req    out  score update pending
//   score_who    out  bell winner (0 = P1, 1 = P2)
//   score_ok     out  1 = correct bell, 0 = wrong bell
//   game_over    out  game finished
//   state_dbg    out  raw state encoding for debug display
// -----------------------------------------------------------------------------
module round_ctrl #(
    parameter int unsigned NUM_CARDS  = 40,
    parameter int unsigned BELL_WIN   = 1000,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_DEALS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flip1,
    input  logic             flip2,
    input  logic             bell1,
    input  logic             bell2,
    input  logic             right,
    input  logic             score_ack,
    output logic             deal_en,
    output logic             whose,
    output logic [CNT_W-1:0] cards_dealt,
    output logic             score_req,
    output logic             score_who,
    output logic             score_ok,
    output logic             game_over,
    output logic [2:0]       state_dbg
);

    localparam int unsigned WIN_W = (BELL_WIN > 2) ? $clog2(BELL_WIN) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(BELL_WIN - 1);
    localparam logic [CNT_W-1:0] CARDS_MAX = CNT_W'(NUM_CARDS);

    // Reject parameter sets that cannot work: a window too short, or a counter
    // too narrow to hold a full deck.
    if (BELL_WIN < 2 || NUM_CARDS >= (64'd1 << CNT_W) || LOCK_DEALS == 0) begin : g_param_chk
        $error("round_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitFlip = 3'd1,
        StDeal     = 3'd2,
        StWatch    = 3'd3,
        StJudge    = 3'd4,
        StScore    = 3'd5,
        StOver     = 3'd6
    } state_e;

    state_e             state_q;
    logic               deal_en_q;
    logic               whose_q;
    logic [CNT_W-1:0]   cards_q;
    logic               score_req_q;
    logic               score_who_q;
    logic               score_ok_q;
    logic               game_over_q;
    logic               tie_pri_q;
    logic [WIN_W-1:0]   win_cnt_q;

`ifdef PENALTY_LOCK_EN
    localparam int unsigned LOCK_W = $clog2(LOCK_DEALS + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_DEALS);
    logic [LOCK_W-1:0]  lock1_q;
    logic [LOCK_W-1:0]  lock2_q;
`endif

    // Bell eligibility and grant. A locked player's press is dropped here, so
    // a simultaneous press with one side locked is never seen as a tie.
    logic elig1, elig2, bell_any, bell_tie, grant, flip_ok;

    always_comb begin
        elig1 = bell1;
        elig2 = bell2;
`ifdef PENALTY_LOCK_EN
        elig1 = bell1 & (lock1_q == '0);
        elig2 = bell2 & (lock2_q == '0);
`endif
        bell_any = elig1 | elig2;
        bell_tie = elig1 & elig2;
        grant    = bell_tie ? tie_pri_q : elig2;
        flip_ok  = whose_q ? flip2 : flip1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            deal_en_q   <= 1'b0;
            whose_q     <= 1'b0;
            cards_q     <= '0;
            score_req_q <= 1'b0;
            score_who_q <= 1'b0;
            score_ok_q  <= 1'b0;
            game_over_q <= 1'b0;
            tie_pri_q   <= 1'b0;
            win_cnt_q   <= '0;
`ifdef PENALTY_LOCK_EN
            lock1_q     <= '0;
            lock2_q     <= '0;
`endif
        end else begin
            deal_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StWaitFlip;
                        whose_q <= 1'b0;
                        cards_q <= '0;
`ifdef PENALTY_LOCK_EN
                        lock1_q <= '0;
                        lock2_q <= '0;
`endif
                    end
                end

                StWaitFlip: begin
                    // A bell outranks a same-cycle flip, but only once a card is on the table.
                    if (bell_any && cards_q != '0) begin
                        state_q     <= StJudge;
                        score_who_q <= grant;
                        if (bell_tie) tie_pri_q <= ~grant;
                    end else if (flip_ok && cards_q < CARDS_MAX) begin
                        state_q   <= StDeal;
                        deal_en_q <= 1'b1;
                    end
                end

                StDeal: begin
                    if (cards_q < CARDS_MAX) cards_q <= cards_q + 1'b1;
                    win_cnt_q <= WIN_LOAD;
                    state_q   <= StWatch;
`ifdef PENALTY_LOCK_EN
                    if (lock1_q != '0) lock1_q <= lock1_q - 1'b1;
                    if (lock2_q != '0) lock2_q <= lock2_q - 1'b1;
`endif
                end

                StWatch: begin
                    if (bell_any) begin
                        state_q     <= StJudge;
                        score_who_q <= grant;
                        if (bell_tie) tie_pri_q <= ~grant;
                    end else if (win_cnt_q == '0) begin
                        whose_q <= ~whose_q;
                        if (cards_q == CARDS_MAX) begin
                            state_q     <= StOver;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= StWaitFlip;
                        end
                    end else begin
                        win_cnt_q <= win_cnt_q - 1'b1;
                    end
                end

                StJudge: begin
                    score_ok_q  <= right;
                    score_req_q <= 1'b1;
                    state_q     <= StScore;
                end

                StScore: begin
                    if (score_ack) begin
                        score_req_q <= 1'b0;
                        whose_q     <= ~whose_q;
`ifdef PENALTY_LOCK_EN
                        if (!score_ok_q) begin
                            if (score_who_q) lock2_q <= LOCK_LOAD;
                            else             lock1_q <= LOCK_LOAD;
                        end
`endif
                        if (cards_q == CARDS_MAX) begin
                            state_q     <= StOver;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= StWaitFlip;
                        end
                    end
                end

                StOver: begin
                    // tie_pri carries over into the next game.
                    if (start) begin
                        state_q     <= StWaitFlip;
                        cards_q     <= '0;
                        whose_q     <= 1'b0;
                        game_over_q <= 1'b0;
`ifdef PENALTY_LOCK_EN
                        lock1_q     <= '0;
                        lock2_q     <= '0;
`endif
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign deal_en     = deal_en_q;
    assign whose       = whose_q;
    assign cards_dealt = cards_q;
    assign score_req   = score_req_q;
    assign score_who   = score_who_q;
    assign score_ok    = score_ok_q;
    assign game_over   = game_over_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_round_ctrl -- directed self-checking bench for round_ctrl.
// DUT is built with a 3-card deck and a 1000-cycle bell window.
// -----------------------------------------------------------------------------
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, flip1, flip2, bell1, bell2, right, score_ack;
    logic       deal_en, whose, score_req, score_who, score_ok, game_over;
    logic [7:0] cards_dealt;
    logic [2:0] state_dbg;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    round_ctrl #(
        .NUM_CARDS (3),
        .BELL_WIN  (1000),
        .CNT_W     (8),
        .LOCK_DEALS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flip1      (flip1),
        .flip2      (flip2),
        .bell1      (bell1),
        .bell2      (bell2),
        .right      (right),
        .score_ack  (score_ack),
        .deal_en    (deal_en),
        .whose      (whose),
        .cards_dealt(cards_dealt),
        .score_req  (score_req),
        .score_who  (score_who),
        .score_ok   (score_ok),
        .game_over  (game_over),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic flip(input logic p1, input logic p2);
        flip1 = p1; flip2 = p2;
        tick();
        flip1 = 1'b0; flip2 = 1'b0;
    endtask

    task automatic bell(input logic b1, input logic b2);
        bell1 = b1; bell2 = b2;
        tick();
        bell1 = 1'b0; bell2 = 1'b0;
    endtask

    task automatic ack();
        score_ack = 1'b1;
        tick();
        score_ack = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; flip1 = 1'b0; flip2 = 1'b0;
        bell1 = 1'b0; bell2 = 1'b0; right = 1'b0; score_ack = 1'b0;
        #12;
        check("rst_state", state_dbg, 0);
        check("rst_deal_en", deal_en, 0);
        check("rst_whose", whose, 0);
        check("rst_cards", cards_dealt, 0);
        check("rst_req", score_req, 0);
        check("rst_over", game_over, 0);
        rst = 1'b1;

        // Inputs other than start are ignored in IDLE.
        flip(1'b1, 1'b0);
        check("idle_flip_ignored", state_dbg, 0);
        check("idle_no_deal", deal_en, 0);

        // ---- Game 1: first deal, window expiry, turn toggle ----
        do_start();
        check("start_state", state_dbg, 1);
        flip(1'b1, 1'b0);
        check("g1_deal_en", deal_en, 1);
        check("g1_deal_state", state_dbg, 2);
        tick();
        check("g1_deal_pulse_end", deal_en, 0);
        check("g1_cards1", cards_dealt, 1);
        check("g1_watch", state_dbg, 3);
        ticks(999);
        check("g1_win_last_cycle", state_dbg, 3);
        tick();
        check("g1_expire_state", state_dbg, 1);
        check("g1_expire_whose", whose, 1);

        // Wrong player's flip is ignored.
        flip(1'b1, 1'b0);
        check("g1_wrong_flip_deal", deal_en, 0);
        check("g1_wrong_flip_state", state_dbg, 1);
        flip(1'b0, 1'b1);
        check("g1_p2_deal", deal_en, 1);
        tick();
        check("g1_p2_deal_once", deal_en, 0);
        check("g1_cards2", cards_dealt, 2);

        // Tie with tie_pri=0: P1 wins.
        right = 1'b1;
        bell(1'b1, 1'b1);
        check("tie1_judge", state_dbg, 4);
        check("tie1_who", score_who, 0);
        tick();
        check("tie1_req", score_req, 1);
        check("tie1_ok", score_ok, 1);
        ticks(3);
        check("tie1_req_held", score_req, 1);
        check("tie1_who_held", score_who, 0);
        check("tie1_state_held", state_dbg, 5);
        ack();
        check("tie1_req_drop", score_req, 0);
        check("tie1_whose", whose, 0);
        check("tie1_back_wait", state_dbg, 1);

        // Second tie: priority has moved to P2.
        flip(1'b1, 1'b0);
        tick();
        check("g1_cards3", cards_dealt, 3);
        bell(1'b1, 1'b1);
        check("tie2_who", score_who, 1);
        right = 1'b0;
        tick();
        check("tie2_ok", score_ok, 0);
        ack();
        check("g1_over_state", state_dbg, 6);
        check("g1_game_over", game_over, 1);
        check("g1_over_whose", whose, 1);
        flip(1'b1, 1'b1);
        check("g1_over_no_deal", deal_en, 0);
        check("g1_over_stays", state_dbg, 6);
        do_start();
        check("restart_cards", cards_dealt, 0);
        check("restart_whose", whose, 0);
        check("restart_over", game_over, 0);
        check("restart_state", state_dbg, 1);

        // ---- Game 2: bell rules in WAIT_FLIP, bell in expiry cycle, deck end ----
        bell(1'b1, 1'b0);
        check("g2_bell_no_cards", state_dbg, 1);
        flip(1'b1, 1'b0);
        tick();
        ticks(1000);
        check("g2_w1_whose", whose, 1);
        check("g2_w1_state", state_dbg, 1);
        // Bell beats a same-cycle flip.
        right = 1'b1;
        bell1 = 1'b1; flip2 = 1'b1;
        tick();
        bell1 = 1'b0; flip2 = 1'b0;
        check("g2_bell_over_flip", state_dbg, 4);
        check("g2_bell_over_flip_deal", deal_en, 0);
        check("g2_bell_over_flip_who", score_who, 0);
        tick();
        check("g2_req", score_req, 1);
        ack();
        check("g2_ack_whose", whose, 0);
        // Bell on the last window cycle wins over expiry.
        flip(1'b1, 1'b0);
        tick();
        ticks(999);
        check("g2_w2_last", state_dbg, 3);
        bell(1'b0, 1'b1);
        check("g2_expiry_bell_state", state_dbg, 4);
        check("g2_expiry_bell_who", score_who, 1);
        tick();
        ack();
        check("g2_w2_whose", whose, 1);
        check("g2_cards2", cards_dealt, 2);
        flip(1'b0, 1'b1);
        tick();
        ticks(1000);
        check("g2_over_state", state_dbg, 6);
        check("g2_game_over", game_over, 1);
        check("g2_whose", whose, 0);
        check("g2_cards_sat", cards_dealt, 3);
        flip(1'b1, 1'b0);
        check("g2_over_no_deal", deal_en, 0);

        // ---- Asynchronous reset while score_req is pending ----
        do_start();
        flip(1'b1, 1'b0);
        tick();
        right = 1'b1;
        bell(1'b0, 1'b1);
        tick();
        check("ar_pre_req", score_req, 1);
        check("ar_pre_who", score_who, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_state", state_dbg, 0);
        check("ar_req", score_req, 0);
        check("ar_who", score_who, 0);
        check("ar_ok", score_ok, 0);
        check("ar_cards", cards_dealt, 0);
        check("ar_over", game_over, 0);
        tick();
        check("ar_held", state_dbg, 0);
        #2;
        rst = 1'b1;

`ifdef PENALTY_LOCK_EN
        // ---- Penalty lock: P1 rings wrong and is locked for two deals ----
        do_start();
        flip(1'b1, 1'b0);
        tick();
        right = 1'b0;
        bell(1'b1, 1'b0);
        tick();
        check("lk_wrong_ok", score_ok, 0);
        ack();
        check("lk_whose", whose, 1);
        flip(1'b0, 1'b1);
        tick();
        bell(1'b1, 1'b0);
        check("lk_p1_ignored", state_dbg, 3);
        right = 1'b1;
        bell(1'b1, 1'b1);
        check("lk_tie_state", state_dbg, 4);
        check("lk_tie_p2", score_who, 1);
        tick();
        ack();
        flip(1'b1, 1'b0);
        tick();
        bell(1'b1, 1'b1);
        check("lk_unlocked_state", state_dbg, 4);
        check("lk_unlocked_p1", score_who, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Game-round sequencer and bell arbiter for the two-player card game.
- Accepts decoded flip/bell key pulses and issues the one-cycle deal strobe to the random/card path.
- Opens a bell window after each deal and arbitrates simultaneous bell presses.
- Runs a req/ack handshake with the score logic and detects end-of-game when the deck is exhausted.

Parameters:
- NUM_CARDS, 40: cards dealt per game.
- BELL_WIN, 1000: bell-window length in clk cycles after each deal (≥2).
- CNT_W, 8: width of the dealt-card counter (2^CNT_W > NUM_CARDS).
- LOCK_DEALS, 2: deals a wrong bell-pusher stays locked out (PENALTY_LOCK_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- flip1, flip2  in  1 each  one-cycle flip-key pulses, player 1 / player 2
- bell1, bell2  in  1 each  one-cycle bell-key pulses
- right  in  1  card-match verdict, valid in JUDGE
- score_ack  in  1  score logic accepted the update
- deal_en  out  1  one-cycle strobe to rand_gen/counter
- whose  out  1  current turn, 0 = P1, 1 = P2
- cards_dealt  out  CNT_W  cards dealt this game
- score_req  out  1  score update pending
- score_who  out  1  bell winner, 0 = P1, 1 = P2
- score_ok  out  1  1 = correct bell, 0 = wrong bell
- game_over  out  1  game finished
- state_dbg  out  3  state encoding, for LED/LCD debug

Behaviour:
- Reset (rst=0, async) clears all state and outputs:
  - state=IDLE; deal_en=0, whose=0, cards_dealt=0, score_req=0, score_who=0, score_ok=0, game_over=0.
  - Tie-priority bit tie_pri=0 (P1).
- Reset mid-operation abandons the round immediately; no score_req survives.
- State encoding: IDLE=0, WAIT_FLIP=1, DEAL=2, WATCH=3, JUDGE=4, SCORE=5, OVER=6.
- IDLE:
  - start → WAIT_FLIP, whose=0, cards_dealt=0.
  - All other inputs are ignored.
- WAIT_FLIP:
  - Flip from the current player (flip1 if whose=0, flip2 if whose=1) → DEAL.
  - Flip from the other player is ignored.
  - Bell accepted only if cards_dealt>0; it goes to JUDGE via arbitration. Bell has priority over a same-cycle flip.
- DEAL (exactly 1 cycle):
  - deal_en=1 in this cycle; cards_dealt += 1 on exit.
  - Next state WATCH; the window counter loads BELL_WIN-1.
- WATCH:
  - Bell → JUDGE; flips are ignored.
  - Window expiry (counter=0, no bell): whose toggles. Go to OVER if cards_dealt==NUM_CARDS, else WAIT_FLIP.
  - A bell in the expiry cycle wins over expiry.
- Arbitration:
  - Single press: grant goes to the presser.
  - bell1&bell2 in the same cycle: grant goes to the player given by tie_pri, then tie_pri is set to the losing player.
  - A single press leaves tie_pri unchanged.
  - The grant is registered into score_who on entry to JUDGE.
- JUDGE (1 cycle): score_ok <= right → SCORE.
- SCORE:
  - score_req=1; score_who and score_ok are held stable until the score_ack cycle.
  - On score_ack: score_req=0 next cycle and whose toggles.
  - Then OVER if cards_dealt==NUM_CARDS, else WAIT_FLIP.
  - score_ack outside SCORE is ignored. No timeout: the block waits indefinitely.
- OVER:
  - game_over=1.
  - start → cards_dealt=0, whose=0, game_over=0, WAIT_FLIP. tie_pri is retained.
- cards_dealt saturates at NUM_CARDS; no further DEAL is possible once equal.
- Latency: flip pulse → deal_en is 1 cycle; bell pulse → score_req is 2 cycles.

Optional Feature:
- Macro: PENALTY_LOCK_EN.
- When defined:
  - A wrong bell (score_ok=0 at SCORE exit) loads a per-player lock counter with LOCK_DEALS.
  - Each DEAL decrements both nonzero counters.
  - A locked player's bell pulses are ignored everywhere.
  - On a simultaneous press with one player locked, the unlocked player is granted and tie_pri is unchanged.
  - Lock counters clear on reset and on start.
- When undefined: no lock counters exist and every bell press is eligible.

Test Plan:
- Reset, start, flip1: deal_en high exactly 1 cycle after the flip; cards_dealt=1; after 1000 idle cycles whose=1 and state=WAIT_FLIP.
- In WAIT_FLIP with whose=1, pulse flip1: no deal_en and state stays 1. Then flip2: deal_en pulses once.
- In WATCH, bell1 and bell2 in the same cycle with tie_pri=0, right=1: score_who=0, score_ok=1, score_req held until score_ack. Repeat the tie: score_who=1.
- NUM_CARDS=3, all windows expire: after the 3rd window game_over=1, state=6, further flips give no deal_en. start → cards_dealt=0, whose=0.
- Assert rst low while score_req=1 and score_ack is withheld: all outputs go to 0 asynchronously, state=0.
- PENALTY_LOCK_EN: P1 rings wrong (right=0), then on the next deal P1 and P2 ring together: P2 granted. After 2 deals P1's bell is honoured again.
